video_memory_sweep: RTL and testbench
=====================================

Name: video_memory_sweep

Overview:
Parametrised dual-port video memory, successor to the fixed 4096x8 character buffer. Same role: one write port from the drawing/calc logic, one read port from the pixel/character scan-out.
Additions over the fixed buffer:
- widths and depth are parameters
- sweep-fill runs on reset and on runtime clear requests
- write port has a ready handshake
- read port has an enable and a valid strobe
- read/write collision policy is selectable

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 12, address width; DEPTH = 2**ADDR_W words
INIT_VALUE, 8'h20, fill word for the post-reset sweep (DATA_W bits)
RW_MODE, 0, same-address read/write collision: 0 = read returns old data, 1 = read returns newly written data

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
init_done  out  1  high once the first post-reset sweep completes; stays high until next reset
busy  out  1  high while any sweep (reset or clear) is running
clr_req  in  1  one-cycle request to fill the whole memory with clr_value
clr_value  in  DATA_W  fill word, sampled when clr_req is accepted
r_en  in  1  read request
r_addr  in  ADDR_W  read address
r_data  out  DATA_W  read data, valid when r_valid
r_valid  out  1  read data strobe
w_addr  in  ADDR_W  write address
w_data  in  DATA_W  write data
w_valid  in  1  write request
w_ready  out  1  write accepted when w_valid & w_ready

Behaviour:
- States: SWEEP, READY. Register fill[DATA_W], sweep counter cnt[ADDR_W].
- Reset (reset_n low, async):
  - state=SWEEP, cnt=0, fill=INIT_VALUE.
  - init_done=0, busy=1, r_valid=0, r_data=0.
  - Memory array is not reset.
- SWEEP:
  - Each clock writes fill to mem[cnt], then cnt+1.
  - On the cycle that writes cnt==DEPTH-1: next state READY, cnt wraps to 0.
  - A full sweep takes exactly DEPTH cycles after reset release.
  - busy drops and init_done rises on the same edge that leaves SWEEP.
  - w_ready=0 for the whole sweep. Masters must hold w_valid/w_addr/w_data. No write is lost or duplicated.
- READY:
  - w_ready=1 (combinational from state only, never from w_valid).
  - Accepted write is committed to mem[w_addr] at the clock edge.
- clr_req in READY:
  - fill<=clr_value, cnt<=0, state<=SWEEP next cycle.
  - A write accepted in the same cycle is committed, then overwritten by the sweep.
  - init_done is unaffected.
- clr_req during SWEEP: restart, fill<=clr_value, cnt<=0. The sweep then takes another DEPTH cycles.
- Reads:
  - r_en accepted in every state.
  - Registered: r_valid and r_data appear on the cycle after r_en. Latency 1.
  - r_valid=0 otherwise; r_data holds its last value.
  - If state==SWEEP in the request cycle, r_data=fill (the value the word will hold), not array contents.
- Collision (READY, r_en & write fire, r_addr==w_addr):
  - RW_MODE=0: r_data = old content.
  - RW_MODE=1: r_data = w_data.
- Reset mid-sweep or mid-operation: immediate abort. The sweep restarts from 0 with INIT_VALUE. Pending read valid is cleared.
- Address arithmetic: cnt wraps modulo DEPTH. No out-of-range addresses exist.

Decomposition:
- Shared package video_mem_pkg:
  - state enum (SWEEP, READY)
  - RW_MODE encodings RW_READ_FIRST=0, RW_WRITE_FIRST=1
  - default blank code 8'h20
- One sub-module, video_mem_array: plain simple-dual-port RAM (one write port, one registered read port), parameterised DATA_W/ADDR_W, inferable as block RAM.
- Sweep control, write muxing and the collision/bypass path live in the top.

Test Plan:
- DEPTH=16, INIT_VALUE=8'h20, release reset_n -> busy high for exactly 16 cycles; init_done rises cycle 16; reading addresses 0..15 -> r_data=8'h20, r_valid one cycle after each r_en.
- Write 8'hA5 to addr 3 in READY; r_en addr 3 next cycle -> r_data=8'hA5 one cycle later; addr 4 still 8'h20.
- Same-cycle write 8'h5A and read to addr 7 holding 8'h11 -> RW_MODE=0 returns 8'h11; RW_MODE=1 returns 8'h5A; next read returns 8'h5A in both.
- clr_req with clr_value=8'h00 while w_valid held (addr 2, 8'h77) -> w_ready low 16 cycles; write lands after busy drops; final mem[2]=8'h77, all other words 8'h00; reads during the sweep return 8'h00.
- Assert reset_n low at sweep cycle 9 of a clear -> busy stays high, new sweep of 16 cycles with 8'h20, init_done low until it finishes.
- Second clr_req (8'hFF) at cycle 5 of a running clear -> sweep restarts; busy lasts 16 more cycles; all words 8'hFF.

Source files
------------

// File: rtl/video_mem_pkg.sv
// Shared types and constants for the video memory.
// No logic; state encoding, collision-mode codes and the blank character code.
package video_mem_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RW_READ_FIRST  = 0;
  localparam int RW_WRITE_FIRST = 1;

  localparam logic [7:0] BLANK_CODE = 8'h20;

endpackage

// File: rtl/video_memory_sweep_if.sv
// Write (valid/ready) and read (enable/valid) ports of the video memory.
// The drawing/scan-out side is the master; the memory is the slave.
interface video_memory_sweep_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);

  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic              w_ready;

  modport master (
    output r_en, r_addr, w_addr, w_data, w_valid,
    input  r_data, r_valid, w_ready
  );

  modport slave (
    input  r_en, r_addr, w_addr, w_data, w_valid,
    output r_data, r_valid, w_ready
  );

endinterface

// File: rtl/video_mem_array.sv
// Simple dual-port RAM, one write port and one registered read port (read-first).
// Read latency 1; no backpressure, every enabled access completes.
module video_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/video_memory_sweep.sv
// Parametrised video memory with sweep-fill on reset and on clear requests.
// Read latency 1; writes are held off (w_ready low) for the whole sweep.
module video_memory_sweep
  import video_mem_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 12,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(BLANK_CODE),
  parameter int                RW_MODE    = RW_READ_FIRST
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              init_done,
  output logic              busy,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] clr_value,
  video_memory_sweep_if.slave bus
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] fill, fill_nx;
  logic              done_nx;
  logic              w_fire;
  logic              bypass_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] ram_rd;
  logic              byp_sel;
  logic [DATA_W-1:0] byp_dat;

  assign bus.w_ready = (state == READY);
  assign busy        = (state == SWEEP);
  assign w_fire      = (state == READY) && bus.w_valid;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fill_nx  = fill;
    done_nx  = init_done;
    if (state == SWEEP) begin
      cnt_nx = cnt + 1'b1;
      if (cnt == '1) begin
        state_nx = READY;
        done_nx  = 1'b1;
      end
    end
    // A clear always wins, including over the last word of a running sweep.
    if (clr_req) begin
      fill_nx  = clr_value;
      cnt_nx   = '0;
      state_nx = SWEEP;
      done_nx  = init_done;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SWEEP;
      cnt       <= '0;
      fill      <= INIT_VALUE;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      fill      <= fill_nx;
      init_done <= done_nx;
    end
  end

  assign mem_we = (state == SWEEP) || w_fire;
  assign mem_wa = (state == SWEEP) ? cnt  : bus.w_addr;
  assign mem_wd = (state == SWEEP) ? fill : bus.w_data;

  video_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk (clk),
    .we  (mem_we),
    .wa  (mem_wa),
    .wd  (mem_wd),
    .re  (bus.r_en),
    .ra  (bus.r_addr),
    .rd  (ram_rd)
  );

  assign bypass_wr = (RW_MODE == RW_WRITE_FIRST) && w_fire && bus.r_en
                     && (bus.r_addr == bus.w_addr);

  // Reads during a sweep return the word's fill value rather than stale RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.r_valid <= 1'b0;
      byp_sel     <= 1'b1;
      byp_dat     <= '0;
    end else begin
      bus.r_valid <= bus.r_en;
      if (bus.r_en) begin
        if (state == SWEEP) begin
          byp_sel <= 1'b1;
          byp_dat <= fill;
        end else if (bypass_wr) begin
          byp_sel <= 1'b1;
          byp_dat <= bus.w_data;
        end else begin
          byp_sel <= 1'b0;
        end
      end
    end
  end

  assign bus.r_data = byp_sel ? byp_dat : ram_rd;

endmodule

// File: tb/tb_video_memory_sweep.sv
// Directed bench: two instances (read-first and write-first) share one stimulus.
module tb_video_memory_sweep;
  import video_mem_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr_req;
  logic [DW-1:0] clr_value;
  logic          init_done0, busy0, init_done1, busy1;

  always #5 clk = ~clk;

  video_memory_sweep_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  video_memory_sweep_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

  assign b1.r_en    = b0.r_en;
  assign b1.r_addr  = b0.r_addr;
  assign b1.w_addr  = b0.w_addr;
  assign b1.w_data  = b0.w_data;
  assign b1.w_valid = b0.w_valid;

  video_memory_sweep #(
    .DATA_W(DW), .ADDR_W(AW), .INIT_VALUE(8'h20), .RW_MODE(RW_READ_FIRST)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .init_done(init_done0), .busy(busy0),
    .clr_req(clr_req), .clr_value(clr_value), .bus(b0)
  );

  video_memory_sweep #(
    .DATA_W(DW), .ADDR_W(AW), .INIT_VALUE(8'h20), .RW_MODE(RW_WRITE_FIRST)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .init_done(init_done1), .busy(busy1),
    .clr_req(clr_req), .clr_value(clr_value), .bus(b1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] e);
    b0.r_en   = 1'b1;
    b0.r_addr = a;
    @(negedge clk);
    b0.r_en = 1'b0;
    chk({nm, "_valid0"}, b0.r_valid, 1);
    chk({nm, "_valid1"}, b1.r_valid, 1);
    chk({nm, "_data0"}, b0.r_data, e);
    chk({nm, "_data1"}, b1.r_data, e);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy0 && n < 40) begin
      if (n == 8) begin
        chk("busy1_mid", busy1, 1);
        chk("w_ready_mid", b0.w_ready, 0);
      end
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    vt[0]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0,  1'b1, 8'h20, 8'h20};
    vt[1]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 1'b1, 8'h20, 8'h20};
    vt[2]  = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0,  1'b0, 8'h20, 8'h20};
    vt[3]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3,  1'b1, 8'hA5, 8'hA5};
    vt[4]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd4,  1'b1, 8'h20, 8'h20};
    vt[5]  = '{1'b1, 4'd7, 8'h11, 1'b0, 4'd0,  1'b0, 8'h20, 8'h20};
    vt[6]  = '{1'b1, 4'd7, 8'h5A, 1'b1, 4'd7,  1'b1, 8'h11, 8'h5A};
    vt[7]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7,  1'b1, 8'h5A, 8'h5A};
    vt[8]  = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0,  1'b0, 8'h5A, 8'h5A};
    vt[9]  = '{1'b1, 4'd0, 8'h3C, 1'b1, 4'd1,  1'b1, 8'h20, 8'h20};
    vt[10] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0,  1'b1, 8'h3C, 8'h3C};

    reset_n   = 1'b0;
    clr_req   = 1'b0;
    clr_value = '0;
    b0.r_en    = 1'b0;
    b0.r_addr  = '0;
    b0.w_addr  = '0;
    b0.w_data  = '0;
    b0.w_valid = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    chk("rst_init_done0", init_done0, 0);
    chk("rst_w_ready0", b0.w_ready, 0);
    chk("rst_r_valid0", b0.r_valid, 0);
    chk("rst_r_data0", b0.r_data, 0);
    chk("rst_r_data1", b1.r_data, 0);

    // Initial sweep, with one read issued during it.
    reset_n   = 1'b1;
    b0.r_en   = 1'b1;
    b0.r_addr = 4'd9;
    n = 0;
    while (busy0 && n < 40) begin
      if (n == 1) begin
        chk("sweep_rd_valid", b0.r_valid, 1);
        chk("sweep_rd_data", b0.r_data, 8'h20);
        b0.r_en = 1'b0;
      end
      if (n == 8) chk("sweep_init_done", init_done0, 0);
      @(negedge clk);
      n++;
    end
    chk("init_sweep_len", n, 16);
    chk("init_done0", init_done0, 1);
    chk("init_done1", init_done1, 1);
    chk("ready_w_ready", b0.w_ready, 1);

    for (int i = 0; i < 16; i++) rd_chk("init_word", 4'(i), 8'h20);

    for (int i = 0; i < 11; i++) begin
      b0.w_valid = vt[i].we;
      b0.w_addr  = vt[i].wa;
      b0.w_data  = vt[i].wd;
      b0.r_en    = vt[i].re;
      b0.r_addr  = vt[i].ra;
      @(negedge clk);
      b0.w_valid = 1'b0;
      b0.r_en    = 1'b0;
      chk($sformatf("vec%0d_valid0", i), b0.r_valid, vt[i].ev);
      chk($sformatf("vec%0d_valid1", i), b1.r_valid, vt[i].ev);
      chk($sformatf("vec%0d_data0", i), b0.r_data, vt[i].e0);
      chk($sformatf("vec%0d_data1", i), b1.r_data, vt[i].e1);
    end

    // Clear to 00 with a write to addr 2 held throughout the sweep.
    clr_req   = 1'b1;
    clr_value = 8'h00;
    @(negedge clk);
    clr_req    = 1'b0;
    b0.w_valid = 1'b1;
    b0.w_addr  = 4'd2;
    b0.w_data  = 8'h77;
    b0.r_en    = 1'b1;
    b0.r_addr  = 4'd5;
    n = 0;
    while (!b0.w_ready && n < 40) begin
      if (n == 3 || n == 12) begin
        chk("clr_rd_valid", b0.r_valid, 1);
        chk("clr_rd_data0", b0.r_data, 8'h00);
        chk("clr_rd_data1", b1.r_data, 8'h00);
        chk("clr_busy", busy0, 1);
      end
      @(negedge clk);
      n++;
    end
    chk("clr_w_ready_low_len", n, 16);
    chk("clr_busy_done", busy0, 0);
    chk("clr_init_done", init_done0, 1);
    @(negedge clk);
    b0.w_valid = 1'b0;
    b0.r_en    = 1'b0;
    for (int i = 0; i < 16; i++) rd_chk("clr_word", 4'(i), (i == 2) ? 8'h77 : 8'h00);

    // Reset in the middle of a clear sweep.
    clr_req   = 1'b1;
    clr_value = 8'hAA;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (8) @(negedge clk);
    b0.r_en   = 1'b1;
    b0.r_addr = 4'd0;
    @(negedge clk);
    b0.r_en = 1'b0;
    chk("midclr_rd_data", b0.r_data, 8'hAA);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy0, 1);
    chk("abort_init_done", init_done0, 0);
    chk("abort_r_valid0", b0.r_valid, 0);
    chk("abort_r_valid1", b1.r_valid, 0);
    chk("abort_r_data", b0.r_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(n);
    chk("rst_sweep_len", n, 16);
    chk("rst_init_done_after", init_done0, 1);
    rd_chk("rst_word0", 4'd0, 8'h20);
    rd_chk("rst_word2", 4'd2, 8'h20);
    rd_chk("rst_word9", 4'd9, 8'h20);
    rd_chk("rst_word15", 4'd15, 8'h20);

    // Second clear restarts a running clear.
    clr_req   = 1'b1;
    clr_value = 8'h33;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (4) @(negedge clk);
    clr_req   = 1'b1;
    clr_value = 8'hFF;
    @(negedge clk);
    clr_req = 1'b0;
    count_busy(n);
    chk("restart_sweep_len", n, 16);
    for (int i = 0; i < 16; i++) rd_chk("restart_word", 4'(i), 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
